// File: rtl/dest_pop_arbiter_pkg.sv
// Shared definitions for the destination-FIFO drain scheduler:
// FSM state encoding, default word width and counter widths.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    localparam int DATA_W_DEF = 6;   // matches data_out_D0/D1 of full_logic
    localparam int CNT_W      = 8;   // delivered-word counters, wrap at 256
    localparam int BURST_W    = 4;   // burst counter, weights are 1..15

endpackage

// File: rtl/dest_pop_arbiter_if.sv
// Bundle of the FIFO drain signals and the downstream valid/ready stream.
// master = arbiter side, slave = environment (FIFOs + link serializer).
interface dest_pop_arbiter_if
    import tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              active_in;
    logic              empty_fifo_D0;
    logic              empty_fifo_D1;
    logic [DATA_W-1:0] data_out_D0;
    logic [DATA_W-1:0] data_out_D1;
    logic              D0_pop;
    logic              D1_pop;
    logic [DATA_W-1:0] out_data;
    logic              out_dest;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  cnt_D0;
    logic [CNT_W-1:0]  cnt_D1;

    modport master (
        input  active_in, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
        output D0_pop, D1_pop, out_data, out_dest, out_valid, cnt_D0, cnt_D1
    );

    modport slave (
        output active_in, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
        input  D0_pop, D1_pop, out_data, out_dest, out_valid, cnt_D0, cnt_D1
    );
endinterface

// File: rtl/dest_pop_arbiter_out_skid_fifo.sv
// Two-entry output FIFO holding {dest, data} words captured after a pop.
// Head drives the downstream stream directly; count feeds the credit check.
module out_skid_fifo #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_rd_fire;

    assign w_rd_fire  = o_rd_valid & i_rd_ready;
    assign o_rd_valid = (r_count != 2'd0);
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage, pointers and occupancy; entries cleared so out_data reads 0 after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_wr_en) - 2'(w_rd_fire);
        end
    end
endmodule

// File: rtl/dest_pop_arbiter.sv
// Weighted round-robin drain of destination FIFOs D0/D1 into one tagged
// valid/ready stream. A pop is only issued when the 2-entry output buffer
// is guaranteed room for it (buffered + in-flight words), so the buffer
// never overflows and the pop strobes never depend on out_data.
module dest_pop_arbiter
    import tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int W0     = 2,
    parameter int W1     = 1
) (
    input  logic               clk,
    input  logic               reset,
    dest_pop_arbiter_if.master io_arb
);
    localparam logic [BURST_W-1:0] W0_L = BURST_W'(W0);
    localparam logic [BURST_W-1:0] W1_L = BURST_W'(W1);

    arb_state_t         r_state, w_state_next;
    logic [BURST_W-1:0] r_burst, w_burst_next, w_burst_inc, w_weight;
    logic               r_last, w_last_next;
    logic               r_inflight, r_inflight_dest;
    logic [CNT_W-1:0]   r_cnt_d0, r_cnt_d1;
    logic [1:0]         w_buf_count;
    logic [DATA_W:0]    w_wr_data, w_rd_data;
    logic               w_rd_valid, w_hs, w_credit_ok;
    logic               w_serving, w_sel, w_sel_empty, w_oth_empty, w_pop;

    // A handshake this cycle frees a slot, so it counts as credit already
    assign w_hs        = w_rd_valid & io_arb.out_ready;
    assign w_credit_ok = ({1'b0, w_buf_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_hs});

    assign w_serving   = (r_state == SERVE0) || (r_state == SERVE1);
    assign w_sel       = (r_state == SERVE1);
    assign w_sel_empty = w_sel ? io_arb.empty_fifo_D1 : io_arb.empty_fifo_D0;
    assign w_oth_empty = w_sel ? io_arb.empty_fifo_D0 : io_arb.empty_fifo_D1;
    assign w_weight    = w_sel ? W1_L : W0_L;
    assign w_pop       = w_serving & io_arb.active_in & w_credit_ok & ~w_sel_empty;
    assign w_burst_inc = r_burst + BURST_W'(w_pop);

    assign io_arb.D0_pop = w_pop & ~w_sel;
    assign io_arb.D1_pop = w_pop & w_sel;

    // Next-state, burst and last-served decode
    always_comb begin
        w_state_next = r_state;
        w_burst_next = r_burst;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (io_arb.active_in) begin
                    w_burst_next = '0;
                    if (!io_arb.empty_fifo_D0 && !io_arb.empty_fifo_D1) begin
                        w_state_next = r_last ? SERVE0 : SERVE1;
                    end else if (!io_arb.empty_fifo_D0) begin
                        w_state_next = SERVE0;
                    end else if (!io_arb.empty_fifo_D1) begin
                        w_state_next = SERVE1;
                    end
                end
            end
            SERVE0, SERVE1: begin
                if (!io_arb.active_in) begin
                    w_state_next = IDLE;
                end else if (w_sel_empty || (w_burst_inc == w_weight)) begin
                    w_burst_next = '0;
                    w_last_next  = w_sel;
                    if (!w_oth_empty) begin
                        w_state_next = w_sel ? SERVE0 : SERVE1;
                    end else if (!w_sel_empty) begin
                        w_state_next = r_state;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_burst_next = w_burst_inc;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register; last=1 so D0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_burst <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_burst <= w_burst_next;
            r_last  <= w_last_next;
        end
    end

    // Remember a pop so its word is captured when the FIFO presents it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight      <= 1'b0;
            r_inflight_dest <= 1'b0;
        end else begin
            r_inflight      <= w_pop;
            r_inflight_dest <= w_sel;
        end
    end

    assign w_wr_data = {r_inflight_dest, r_inflight_dest ? io_arb.data_out_D1 : io_arb.data_out_D0};

    out_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (r_inflight),
        .i_wr_data  (w_wr_data),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (w_rd_valid),
        .i_rd_ready (io_arb.out_ready),
        .o_count    (w_buf_count)
    );

    // Per-destination delivered-word counters, wrapping modulo 256
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else if (w_hs) begin
            if (w_rd_data[DATA_W]) begin
                r_cnt_d1 <= r_cnt_d1 + 1'b1;
            end else begin
                r_cnt_d0 <= r_cnt_d0 + 1'b1;
            end
        end
    end

    assign io_arb.out_data  = w_rd_data[DATA_W-1:0];
    assign io_arb.out_dest  = w_rd_data[DATA_W];
    assign io_arb.out_valid = w_rd_valid;
    assign io_arb.cnt_D0    = r_cnt_d0;
    assign io_arb.cnt_D1    = r_cnt_d1;
endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Bench for dest_pop_arbiter: queue-based FIFO models feed the DUT, a
// scoreboard predicts the output stream (pop order, two-cycle latency,
// hold while stalled) and the counters; directed scenarios check the
// scheduling pattern, credit stall, active drop and counter wrap.
module tb_dest_pop_arbiter;
    import tx_pkg::*;

    localparam int DATA_W = 6;
    localparam int W0     = 2;
    localparam int W1     = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dest_pop_arbiter_if #(.DATA_W(DATA_W)) bus ();

    dest_pop_arbiter #(
        .DATA_W (DATA_W),
        .W0     (W0),
        .W1     (W1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_arb (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              dest;
        int                avail;
    } exp_t;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc   = 0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    exp_t              exp_q[$];
    int                pop_log[$];
    logic [DATA_W:0]   dlv_log[$];
    logic              pend0 = 1'b0;
    logic              pend1 = 1'b0;
    logic [7:0]        m_cnt0 = 8'd0;
    logic [7:0]        m_cnt1 = 8'd0;
    logic              act = 1'b1;
    logic              rdy = 1'b1;
    logic              rst_drv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: apply FIFO/driver updates just after the edge, check at the falling edge
    task automatic cycle();
        logic p0, p1, ev;
        @(posedge clk);
        #1;
        cyc++;
        if (pend0 && q0.size() != 0) bus.data_out_D0 = q0.pop_front();
        if (pend1 && q1.size() != 0) bus.data_out_D1 = q1.pop_front();
        pend0 = 1'b0;
        pend1 = 1'b0;
        reset = rst_drv;
        if (!rst_drv) begin
            exp_q.delete();
            m_cnt0 = 8'd0;
            m_cnt1 = 8'd0;
        end
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
        bus.active_in     = act;
        bus.out_ready     = rdy;
        @(negedge clk);
        p0 = bus.D0_pop;
        p1 = bus.D1_pop;
        check("pop_onehot", {31'd0, p0 & p1}, 32'd0);
        if (p0) check("pop0_legal", {30'd0, bus.active_in, bus.empty_fifo_D0}, 32'd2);
        if (p1) check("pop1_legal", {30'd0, bus.active_in, bus.empty_fifo_D1}, 32'd2);
        ev = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        if (ev) begin
            check("out_data", {26'd0, bus.out_data}, {26'd0, exp_q[0].data});
            check("out_dest", {31'd0, bus.out_dest}, {31'd0, exp_q[0].dest});
        end
        check("cnt_D0", {24'd0, bus.cnt_D0}, {24'd0, m_cnt0});
        check("cnt_D1", {24'd0, bus.cnt_D1}, {24'd0, m_cnt1});
        if (ev && bus.out_ready) begin
            dlv_log.push_back({exp_q[0].dest, exp_q[0].data});
            if (exp_q[0].dest) m_cnt1++;
            else               m_cnt0++;
            void'(exp_q.pop_front());
        end
        if (p0 && q0.size() != 0) begin
            exp_q.push_back('{data: q0[0], dest: 1'b0, avail: cyc + 2});
            pend0 = 1'b1;
        end
        if (p1 && q1.size() != 0) begin
            exp_q.push_back('{data: q1[0], dest: 1'b1, avail: cyc + 2});
            pend1 = 1'b1;
        end
        if (p0 || p1) check("outstanding_le2", {31'd0, exp_q.size() <= 2}, 32'd1);
        pop_log.push_back(p0 ? 0 : (p1 ? 1 : -1));
    endtask

    task automatic reset_pulse();
        rst_drv = 1'b0;
        cycle();
        rst_drv = 1'b1;
        pop_log.delete();
        dlv_log.delete();
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || pend0 || pend1) && k < limit) begin
            cycle();
            k++;
        end
        check("drain_done", {31'd0, (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0)}, 32'd1);
    endtask

    function automatic int first_pop();
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] != -1) return i;
        return -1;
    endfunction

    function automatic int log_at(input int i);
        if (i < 0 || i >= pop_log.size()) return -2;
        return pop_log[i];
    endfunction

    function automatic int pop_total();
        int n;
        n = 0;
        foreach (pop_log[i]) if (pop_log[i] != -1) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int seq3[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        logic found;
        bus.active_in     = 1'b0;
        bus.out_ready     = 1'b0;
        bus.empty_fifo_D0 = 1'b1;
        bus.empty_fifo_D1 = 1'b1;
        bus.data_out_D0   = '0;
        bus.data_out_D1   = '0;
        #2 reset = 1'b0;

        // Reset held 3 cycles with both FIFOs loaded
        for (int i = 0; i < 4; i++) q0.push_back(DATA_W'(8'h05 + i));
        for (int i = 0; i < 2; i++) q1.push_back(DATA_W'(8'h25 + i));
        rst_drv = 1'b0;
        repeat (3) cycle();
        check("rst_D0_pop", {31'd0, bus.D0_pop}, 32'd0);
        check("rst_D1_pop", {31'd0, bus.D1_pop}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {26'd0, bus.out_data}, 32'd0);
        check("rst_out_dest", {31'd0, bus.out_dest}, 32'd0);
        rst_drv = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            cycle();
            if (pop_log[$] == 0) found = 1'b1;
        end
        check("first_pop_D0_within2", {31'd0, found}, 32'd1);
        drain(60);

        // D0 only: three back-to-back pops, words out in order, cnt_D0 = 3
        reset_pulse();
        q0.push_back(6'h11); q0.push_back(6'h12); q0.push_back(6'h13);
        drain(30);
        cycle();
        f = first_pop();
        check("t2_pop_found", {31'd0, f >= 0}, 32'd1);
        for (int k = 0; k < 3; k++) check("t2_pop_seq", log_at(f + k), 0);
        check("t2_pop_end", log_at(f + 3), -1);
        check("t2_dlv_n", dlv_log.size(), 3);
        for (int k = 0; k < 3 && k < dlv_log.size(); k++) check("t2_dlv", {25'd0, dlv_log[k]}, 32'h11 + k);
        check("t2_cnt_D0", {24'd0, bus.cnt_D0}, 32'd3);

        // Both loaded: weighted pattern D0,D0,D1 with no gaps
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(DATA_W'(8'h20 + i));
            q1.push_back(DATA_W'(8'h30 + i));
        end
        drain(60);
        f = first_pop();
        for (int k = 0; k < 12; k++) check("t3_wrr_seq", log_at(f + k), seq3[k]);

        // Downstream stalled: only two pops fit, then everything drains in order
        reset_pulse();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) q0.push_back(DATA_W'(i + 1));
        repeat (10) cycle();
        check("t4_pops_while_stalled", pop_total(), 2);
        rdy = 1'b1;
        drain(40);
        check("t4_pops_total", pop_total(), 5);
        check("t4_dlv_n", dlv_log.size(), 5);
        for (int k = 0; k < 5 && k < dlv_log.size(); k++) check("t4_dlv", {25'd0, dlv_log[k]}, k + 1);

        // active_in dropped at the second pop of a D0 burst
        reset_pulse();
        for (int i = 0; i < 4; i++) q0.push_back(DATA_W'(8'h08 + i));
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            cycle();
            if (pop_log[$] == 0) found = 1'b1;
        end
        check("t5_first_pop", {31'd0, found}, 32'd1);
        act = 1'b0;
        cycle();
        check("t5_no_pop_on_drop", pop_log[$], -1);
        act = 1'b1;
        cycle();
        check("t5_idle_after_drop", pop_log[$], -1);
        cycle();
        check("t5_resume_pop", pop_log[$], 0);
        drain(40);
        check("t5_dlv_n", dlv_log.size(), 4);
        for (int k = 0; k < 4 && k < dlv_log.size(); k++) check("t5_dlv", {25'd0, dlv_log[k]}, 32'h08 + k);

        // 257 D1 words: cnt_D1 wraps to 1, cnt_D0 untouched
        reset_pulse();
        for (int i = 0; i < 257; i++) q1.push_back(DATA_W'(i));
        drain(400);
        cycle();
        check("t6_cnt_D1_wrap", {24'd0, bus.cnt_D1}, 32'd1);
        check("t6_cnt_D0_zero", {24'd0, bus.cnt_D0}, 32'd0);

        // Random traffic, flow control, activity and occasional reset
        reset_pulse();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DATA_W'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DATA_W'($urandom));
            act     = ($urandom_range(0, 7) != 0);
            rdy     = ($urandom_range(0, 2) != 0);
            rst_drv = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rst_drv = 1'b1;
        act = 1'b1;
        rdy = 1'b1;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
